fire_expand1_sched: RTL

FIRE_EXPAND1_SCHED -- requirements
Module: fire_expand1_sched

---
 rtl/fire_expand1_sched_if.sv | 11 +
 rtl/fire_expand1_sif.sv | 33 +++
 rtl/fire_expand1_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/fire_expand1_sched_if.sv
// State encoding shared by the expand1 scheduler; the handshake interface is in fire_expand1_sif.sv.
// Five-state pass FSM: IDLE, RUN, GAP, FLUSH, DONE.
package fire_expand1_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_GAP   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/fire_expand1_sif.sv
// Handshake bundle between the expand1 scheduler and its environment.
// master = scheduler side, slave = controller / RAM side.
interface fire_expand1_sched_if #(
  parameter int WOUT = 64,
  parameter int CHIN = 16
);
  localparam int NPIX = WOUT * WOUT;
  localparam int AW   = $clog2(NPIX * CHIN);
  localparam int PW   = $clog2(NPIX);

  logic          start;
  logic          layer_sel;
  logic          abort;
  logic          wr_ready;
  logic          fire2_en;
  logic          fire3_en;
  logic          ifm_rd_en;
  logic [AW-1:0] ifm_addr;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic          busy;
  logic          done;

  modport master (
    input  start, layer_sel, abort, wr_ready,
    output fire2_en, fire3_en, ifm_rd_en, ifm_addr, wr_en, wr_addr, busy, done
  );

  modport slave (
    output start, layer_sel, abort, wr_ready,
    input  fire2_en, fire3_en, ifm_rd_en, ifm_addr, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/fire_expand1_sched.sv
// Expand1 layer scheduler: walks pixels x channels of the squeeze RAM, one MAC-clear slot per pixel.
// Latency NPIX*(CHIN+1)+2 unstalled; a pending result write stalls the next GAP until wr_ready.
module fire_expand1_sched
  import fire_expand1_sched_pkg::*;
#(
  parameter int WOUT = 64,
  parameter int CHIN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fire_expand1_sched_if.master  bus
);
  localparam int NPIX = WOUT * WOUT;
  localparam int AW   = $clog2(NPIX * CHIN);
  localparam int PW   = $clog2(NPIX);
  localparam int CW   = (CHIN > 1) ? $clog2(CHIN) : 1;

  state_t        state_q;
  logic          sel_q;
  logic [CW-1:0] ch_q;
  logic [PW-1:0] pix_q;
  logic [AW-1:0] addr_q;
  logic [PW-1:0] wr_addr_q;
  logic          pend_q;
  logic          stall_q;

  logic          last_ch;
  logic          last_pix;
  logic [CW-1:0] ch_d;
  logic          active;

  assign last_ch  = (ch_q == CW'(CHIN - 1));
  assign last_pix = (pix_q == PW'(NPIX - 1));
  assign ch_d     = last_ch ? '0 : ch_q + 1'b1;

  // The first GAP cycle is the MAC clear slot; extra GAP cycles are stall and keep the datapath idle.
  assign active = (state_q == S_RUN) || ((state_q == S_GAP) && !stall_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      ch_q      <= '0;
      pix_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      pend_q    <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      if (pend_q && bus.wr_ready) pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sel_q   <= bus.layer_sel;
            ch_q    <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            stall_q <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          ch_q    <= ch_d;
          stall_q <= 1'b0;
          if (!(last_ch && last_pix)) addr_q <= addr_q + 1'b1;
          if (last_ch) state_q <= S_GAP;
        end
        S_GAP: begin
          if (pend_q && !bus.wr_ready) begin
            stall_q <= 1'b1;
          end else begin
            stall_q   <= 1'b0;
            pend_q    <= 1'b1;
            wr_addr_q <= pix_q;
            if (last_pix) begin
              state_q <= S_FLUSH;
            end else begin
              pix_q   <= pix_q + 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_FLUSH: begin
          if (!pend_q || bus.wr_ready) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      if (bus.abort && (state_q != S_IDLE)) begin
        state_q   <= S_IDLE;
        pend_q    <= 1'b0;
        stall_q   <= 1'b0;
        ch_q      <= '0;
        pix_q     <= '0;
        addr_q    <= '0;
        wr_addr_q <= '0;
      end
    end
  end

  assign bus.fire2_en  = active && !sel_q;
  assign bus.fire3_en  = active && sel_q;
  assign bus.ifm_rd_en = (state_q == S_RUN);
  assign bus.ifm_addr  = addr_q;
  assign bus.wr_en     = pend_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
endmodule
